// File: rtl/naive_cpu_pkg.sv
// Shared definitions for the naive CPU keyboard path: the mapped address,
// the status-bit positions in the keyboard word and the PS/2 receiver states.
package naive_cpu_pkg;

  localparam logic [15:0] KEYBOARD_ADDR    = 16'hFE00;
  localparam int          KBD_READY_BIT    = 15;
  localparam int          KBD_OVERFLOW_BIT = 14;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: pin synchronisers, falling-edge detect,
// start/data/parity/stop FSM and a mid-frame inactivity timeout.
module ps2_frame_rx
  import naive_cpu_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic       byteValid,
  output logic [7:0] rxByte,
  output logic       frameError
);

  logic      clk_sync1_q, clk_sync2_q, clk_prev_q;
  logic      dat_sync1_q, dat_sync2_q;
  logic      fall_edge;
  rx_state_e state_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_cnt_q;
  logic        parity_ok_q;
  logic [15:0] tmo_q;
  logic        byte_valid_q, frame_error_q;
  logic [7:0]  byte_q;

  // Synchronisers idle high so reset never looks like a bus falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync1_q <= 1'b1;
      clk_sync2_q <= 1'b1;
      clk_prev_q  <= 1'b1;
      dat_sync1_q <= 1'b1;
      dat_sync2_q <= 1'b1;
    end else begin
      clk_sync1_q <= ps2Clk;
      clk_sync2_q <= clk_sync1_q;
      clk_prev_q  <= clk_sync2_q;
      dat_sync1_q <= ps2Data;
      dat_sync2_q <= dat_sync1_q;
    end
  end

  assign fall_edge = clk_prev_q & ~clk_sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RX_IDLE;
      shift_q       <= 8'h00;
      bit_cnt_q     <= 3'd0;
      parity_ok_q   <= 1'b0;
      tmo_q         <= 16'd0;
      byte_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      byte_q        <= 8'h00;
    end else begin
      byte_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      if (fall_edge) begin
        tmo_q <= 16'd0;
        case (state_q)
          RX_IDLE: begin
            if (!dat_sync2_q) begin
              state_q   <= RX_DATA;
              shift_q   <= 8'h00;
              bit_cnt_q <= 3'd0;
            end
          end
          RX_DATA: begin
            shift_q   <= {dat_sync2_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= RX_PARITY;
          end
          RX_PARITY: begin
            parity_ok_q <= ^shift_q ^ dat_sync2_q;
            state_q     <= RX_STOP;
          end
          RX_STOP: begin
            if (dat_sync2_q && parity_ok_q) begin
              byte_valid_q <= 1'b1;
              byte_q       <= shift_q;
            end else begin
              frame_error_q <= 1'b1;
            end
            state_q <= RX_IDLE;
          end
          default: state_q <= RX_IDLE;
        endcase
      end else if (state_q != RX_IDLE) begin
        if (tmo_q == TIMEOUT_CYCLES - 16'd1) begin
          state_q       <= RX_IDLE;
          frame_error_q <= 1'b1;
          tmo_q         <= 16'd0;
        end else begin
          tmo_q <= tmo_q + 16'd1;
        end
      end
    end
  end

  assign byteValid  = byte_valid_q;
  assign rxByte     = byte_q;
  assign frameError = frame_error_q;

endmodule

// File: rtl/ps2_keyboard_buffer.sv
// PS/2 keyboard input stage: received scan codes go into a small FIFO whose
// head is presented to the CPU as {ready, overflow, 6'b0, scanCode}.
module ps2_keyboard_buffer
  import naive_cpu_pkg::*;
#(
  parameter int          FIFO_DEPTH_LOG2 = 3,
  parameter logic [15:0] TIMEOUT_CYCLES  = 16'd50000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ps2Clk,
  input  logic                     ps2Data,
  input  logic                     readStrobe,
  output logic [15:0]              keyboardData,
  output logic [FIFO_DEPTH_LOG2:0] fifoCount,
  output logic                     frameError
);

  localparam int PTR_W = FIFO_DEPTH_LOG2;
  localparam int CNT_W = FIFO_DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

  logic             rx_valid, rx_error;
  logic [7:0]       rx_byte;
  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             frame_error_q;
  logic             do_push, do_pop, ready;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2Clk    (ps2Clk),
    .ps2Data   (ps2Data),
    .byteValid (rx_valid),
    .rxByte    (rx_byte),
    .frameError(rx_error)
  );

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  always_comb begin
    do_pop     = readStrobe && (count_q != '0);
    do_push    = rx_valid && ((count_q != CNT_W'(DEPTH)) || do_pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (rx_valid && !do_push) overflow_d = 1'b1;
    else if (readStrobe)      overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      frame_error_q <= rx_error;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= rx_byte;
  end

  always_comb begin
    ready                          = (count_q != '0);
    keyboardData                   = 16'h0000;
    keyboardData[KBD_READY_BIT]    = ready;
    keyboardData[KBD_OVERFLOW_BIT] = overflow_q;
    keyboardData[7:0]              = ready ? mem_q[rd_ptr_q] : 8'h00;
  end

  assign fifoCount  = count_q;
  assign frameError = frame_error_q;

endmodule

// File: tb/tb_ps2_keyboard_buffer.sv
// Directed bench for ps2_keyboard_buffer: bit-banged PS/2 frames, CPU pops,
// overflow, simultaneous push/pop, timeout and asynchronous reset.
module tb_ps2_keyboard_buffer;

  localparam int          LOG2 = 3;
  localparam logic [15:0] TMO  = 16'd400;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ps2Clk = 1'b1;
  logic          ps2Data = 1'b1;
  logic          readStrobe = 1'b0;
  logic [15:0]   keyboardData;
  logic [LOG2:0] fifoCount;
  logic          frameError;

  int n_checks = 0;
  int n_pass   = 0;
  int err_cnt  = 0;
  logic [15:0] pop_word;

  ps2_keyboard_buffer #(
    .FIFO_DEPTH_LOG2(LOG2),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2Clk      (ps2Clk),
    .ps2Data     (ps2Data),
    .readStrobe  (readStrobe),
    .keyboardData(keyboardData),
    .fifoCount   (fifoCount),
    .frameError  (frameError)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frameError) err_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish within 2 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
  endtask

  task automatic send_bit(input logic b, input bit pop_at_push);
    ps2Data = b;
    repeat (4) @(negedge clk);
    ps2Clk = 1'b0;
    if (pop_at_push) begin
      repeat (3) @(negedge clk);
      pop_word   = keyboardData;
      readStrobe = 1'b1;
      @(negedge clk);
      readStrobe = 1'b0;
    end else begin
      repeat (4) @(negedge clk);
    end
    ps2Clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit pop_at_stop);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
    send_bit((~^b) ^ bad_par, 1'b0);
    send_bit(1'b1, pop_at_stop);
    repeat (4) @(negedge clk);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(b[i], 1'b0);
  endtask

  task automatic pop(input string tag, input logic [15:0] exp);
    @(negedge clk);
    chk(tag, keyboardData, exp);
    readStrobe = 1'b1;
    @(negedge clk);
    readStrobe = 1'b0;
  endtask

  initial begin
    int e0;
    repeat (3) @(negedge clk);
    chk("reset_kd", keyboardData, 16'h0000);
    chk("reset_cnt", fifoCount, 0);
    chk("reset_ferr", frameError, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    send_frame(8'h1C, 1'b0, 1'b0);
    chk("rx1c_kd", keyboardData, 16'h801C);
    chk("rx1c_cnt", fifoCount, 1);
    pop("rx1c_pop", 16'h801C);
    chk("rx1c_after_kd", keyboardData, 16'h0000);
    chk("rx1c_after_cnt", fifoCount, 0);

    e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b0);
    chk("par_err_pulses", err_cnt - e0, 1);
    chk("par_err_cnt", fifoCount, 0);
    chk("par_err_kd", keyboardData, 16'h0000);

    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
    chk("ovf_cnt", fifoCount, 8);
    chk("ovf_kd", keyboardData, 16'hC001);
    pop("ovf_pop1", 16'hC001);
    chk("ovf_cleared", keyboardData, 16'h8002);
    for (int i = 2; i <= 8; i++) pop("ovf_popn", 16'h8000 | 16'(i));
    chk("ovf_empty_kd", keyboardData, 16'h0000);
    chk("ovf_empty_cnt", fifoCount, 0);

    for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b0, 1'b0);
    chk("full_cnt", fifoCount, 8);
    send_frame(8'h0A, 1'b0, 1'b1);
    chk("simul_popword", pop_word, 16'h8011);
    chk("simul_cnt", fifoCount, 8);
    chk("simul_kd", keyboardData, 16'h8012);
    for (int i = 2; i <= 8; i++) pop("simul_pop", 16'h8000 | (16'h0010 + 16'(i)));
    pop("simul_last", 16'h800A);
    chk("simul_empty", fifoCount, 0);

    e0 = err_cnt;
    send_partial(8'h5A, 5);
    repeat (int'(TMO) + 20) @(negedge clk);
    chk("tmo_pulses", err_cnt - e0, 1);
    chk("tmo_cnt", fifoCount, 0);
    send_frame(8'h5A, 1'b0, 1'b0);
    chk("tmo_next_kd", keyboardData, 16'h805A);
    pop("tmo_pop", 16'h805A);

    send_frame(8'h33, 1'b0, 1'b0);
    send_frame(8'h44, 1'b0, 1'b0);
    chk("rst_pre_cnt", fifoCount, 2);
    e0 = err_cnt;
    send_partial(8'h29, 4);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_kd", keyboardData, 16'h0000);
    chk("rst_async_cnt", fifoCount, 0);
    chk("rst_async_ferr", frameError, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (int'(TMO) + 20) @(negedge clk);
    chk("rst_no_err", err_cnt - e0, 0);
    send_frame(8'h29, 1'b0, 1'b0);
    chk("rst_next_kd", keyboardData, 16'h8029);
    chk("rst_next_cnt", fifoCount, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
